// File: rtl/led_trail_pwm_if.sv
// Cursor bus from the shifter into the trail renderer: one-hot position plus a per-move strobe.
interface led_trail_pwm_if #(
   parameter int unsigned N_LEDS = 26
);
   logic              step;
   logic [N_LEDS-1:0] cursor;

   modport master (output step, output cursor);
   modport slave  (input  step, input  cursor);
endinterface

// File: rtl/led_trail_pwm.sv
// Renders a decaying PWM trail of the cursor on LEDR/LEDG; KEY presses adjust the peak width,
// which is shown in hex on HEX1:HEX0.
module led_trail_pwm #(
   parameter int unsigned N_LEDS      = 26,
   parameter int unsigned PWM_BITS    = 8,
   parameter int unsigned DECAY_SHIFT = 1,
   parameter int unsigned KEY_STEP    = 16,
   parameter int unsigned LOCK_BITS   = 20
) (
   input  logic           CLOCK_50,
   input  logic           RESET,
   led_trail_pwm_if.slave cur,
   input  logic           key_up,
   input  logic           key_dn,
   output logic [17:0]    LEDR,
   output logic [7:0]     LEDG,
   output logic [6:0]     HEX0,
   output logic [6:0]     HEX1
);
   localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;
   localparam logic [PWM_BITS-1:0] PEAK_RST = {1'b1, {(PWM_BITS-1){1'b0}}};
   localparam logic [PWM_BITS-1:0] STEP_W   = PWM_BITS'(KEY_STEP);

   logic [PWM_BITS-1:0]  r_pwm_cnt;
   logic [PWM_BITS-1:0]  r_width  [N_LEDS];
   logic [PWM_BITS-1:0]  r_shadow [N_LEDS];
   logic [N_LEDS-1:0]    r_led;
   logic [PWM_BITS-1:0]  r_peak;
   logic [2:0]           r_up_sync;
   logic [2:0]           r_dn_sync;
   logic [LOCK_BITS-1:0] r_lock;
   logic [6:0]           r_hex0;
   logic [6:0]           r_hex1;

   logic                 w_acc_up;
   logic                 w_acc_dn;
   logic [PWM_BITS-1:0]  w_peak_nxt;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      seg7 = '1;
      case (n)
         4'h0: seg7 = 7'h40;
         4'h1: seg7 = 7'h79;
         4'h2: seg7 = 7'h24;
         4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;
         4'h5: seg7 = 7'h12;
         4'h6: seg7 = 7'h02;
         4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;
         4'h9: seg7 = 7'h10;
         4'hA: seg7 = 7'h08;
         4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;
         4'hD: seg7 = 7'h21;
         4'hE: seg7 = 7'h06;
         4'hF: seg7 = 7'h0E;
      endcase
   endfunction

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         for (int unsigned i = 0; i < N_LEDS; i++) begin
            r_width[i]  <= '0;
            r_shadow[i] <= '0;
         end
         r_led <= '0;
      end else begin
         for (int unsigned i = 0; i < N_LEDS; i++) begin
            if (cur.step) begin
               r_width[i] <= cur.cursor[i] ? r_peak : (r_width[i] >> DECAY_SHIFT);
            end
            // Shadow copy only at the period wrap so a duty cycle never changes mid-period.
            if (r_pwm_cnt == PWM_MAX) begin
               r_shadow[i] <= r_width[i];
            end
            r_led[i] <= (r_pwm_cnt < r_shadow[i]);
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         r_up_sync <= '1;
         r_dn_sync <= '1;
      end else begin
         r_up_sync <= {r_up_sync[1:0], key_up};
         r_dn_sync <= {r_dn_sync[1:0], key_dn};
      end
   end

   // Bit 1 is the synchronised key, bit 2 its previous value: a press is a 1->0 transition.
   assign w_acc_up = r_up_sync[2] & ~r_up_sync[1] & (r_lock == '0);
   assign w_acc_dn = r_dn_sync[2] & ~r_dn_sync[1] & (r_lock == '0);

   always_comb begin
      w_peak_nxt = r_peak;
      if (w_acc_up && !w_acc_dn) begin
         w_peak_nxt = (r_peak > (PWM_MAX - STEP_W)) ? PWM_MAX : (r_peak + STEP_W);
      end else if (w_acc_dn && !w_acc_up) begin
         w_peak_nxt = (r_peak < STEP_W) ? '0 : (r_peak - STEP_W);
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         r_peak <= PEAK_RST;
         r_lock <= '0;
      end else begin
         r_peak <= w_peak_nxt;
         if (w_acc_up || w_acc_dn) begin
            r_lock <= '1;
         end else if (r_lock != '0) begin
            r_lock <= r_lock - LOCK_BITS'(1);
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         r_hex0 <= seg7(PEAK_RST[3:0]);
         r_hex1 <= seg7(PEAK_RST[7:4]);
      end else begin
         r_hex0 <= seg7(r_peak[3:0]);
         r_hex1 <= seg7(r_peak[7:4]);
      end
   end

   assign {LEDR, LEDG} = r_led;
   assign HEX0         = r_hex0;
   assign HEX1         = r_hex1;

endmodule
